// File: rtl/buffer_rr_scheduler.sv
// buffer_rr_scheduler
// Round-robin arbiter sharing one circular buffer write port among NUM_REQ
// producers, plus a read sequencer that presents the buffer contents as a
// valid/ready stream tagged with the originating requester index.
// Optional statistics counters are built when BUFF_RR_SCHED_STATS_EN is defined.
module buffer_rr_scheduler #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 64,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic                             buf_wr_en_o,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]   buf_wdata_o,
    input  logic                             buf_full_i,
    output logic                             buf_rd_en_o,
    input  logic [ID_WIDTH+DATA_WIDTH-1:0]   buf_rdata_i,
    input  logic                             buf_empty_i,
    output logic                             out_valid_o,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    output logic [ID_WIDTH-1:0]              out_src_o,
    input  logic                             out_ready_i,
    output logic                             idle_o
`ifdef BUFF_RR_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]            stat_grant_cnt_o,
    output logic [15:0]                      stat_full_stall_cnt_o
`endif
);

    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic                  ov_q, ov_d;
    logic [NUM_REQ-1:0]    eligible;
    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [NUM_REQ-1:0]    grant_vec;
    logic [DATA_WIDTH-1:0] grant_payload;
    logic                  rd_en;
    int                    cand;

    // A full buffer blocks every requester; a same-cycle read never makes room.
    assign eligible = req_valid_i & {NUM_REQ{~buf_full_i}};

    // Search ptr, ptr+1, ... (mod NUM_REQ) for the first eligible requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(cand);
            end
        end
    end

    // One-hot grant, payload mux and pointer advance past the winner.
    always_comb begin
        grant_vec     = '0;
        grant_payload = '0;
        ptr_d         = ptr_q;
        if (grant_found && !srst) begin
            grant_vec[grant_idx] = 1'b1;
            ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_WIDTH'(k)) begin
                grant_payload = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign req_ready_o = grant_vec;
    assign buf_wr_en_o = |grant_vec;
    assign buf_wdata_o = {grant_idx, grant_payload};

    // Read whenever the output register is free or being drained this cycle.
    always_comb begin
        rd_en = ~srst & ~buf_empty_i & (~ov_q | out_ready_i);
        ov_d  = ov_q;
        if (rd_en) begin
            ov_d = 1'b1;
        end else if (ov_q && out_ready_i) begin
            ov_d = 1'b0;
        end
    end

    assign buf_rd_en_o = rd_en;
    assign out_valid_o = ov_q;
    assign out_data_o  = buf_rdata_i[DATA_WIDTH-1:0];
    assign out_src_o   = buf_rdata_i[DATA_WIDTH +: ID_WIDTH];
    assign idle_o      = ~ov_q & buf_empty_i;

    // Pointer and output-valid registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ov_q  <= ov_d;
        end
    end

`ifdef BUFF_RR_SCHED_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] grant_cnt_d [NUM_REQ];
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating per-requester grant counters and full-stall counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|req_valid_i) && buf_full_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_cnt_d[k] = grant_cnt_q[k];
            if (grant_vec[k] && (grant_cnt_q[k] != 16'hFFFF)) begin
                grant_cnt_d[k] = grant_cnt_q[k] + 16'd1;
            end
        end
    end

    // Counter registers, cleared with the rest of the block.
    always_ff @(posedge clk) begin
        if (srst) begin
            stall_cnt_q <= '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= '0;
            end
        end else begin
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= grant_cnt_d[k];
            end
        end
    end

    // Flatten the counter array onto the output bus.
    always_comb begin
        stat_grant_cnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            stat_grant_cnt_o[k*16 +: 16] = grant_cnt_q[k];
        end
    end

    assign stat_full_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_buffer_rr_scheduler.sv
// Directed bench for buffer_rr_scheduler with a 2-entry circular buffer model.
module tb_buffer_rr_scheduler;

    localparam int NR = 3;
    localparam int DW = 8;
    localparam int IW = 2;
    localparam int BW = IW + DW;

    logic              clk = 1'b0;
    logic              srst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              buf_wr_en;
    logic [BW-1:0]     buf_wdata;
    logic              buf_full;
    logic              buf_rd_en;
    logic [BW-1:0]     buf_rdata;
    logic              buf_empty;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_src;
    logic              out_ready;
    logic              idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffer_rr_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .srst        (srst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .buf_wr_en_o (buf_wr_en),
        .buf_wdata_o (buf_wdata),
        .buf_full_i  (buf_full),
        .buf_rd_en_o (buf_rd_en),
        .buf_rdata_i (buf_rdata),
        .buf_empty_i (buf_empty),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_ready_i (out_ready),
        .idle_o      (idle)
    );

    // Circular buffer model, depth 2, registered read data, async reset from srst.
    logic          arst_n;
    logic [BW-1:0] mem [2];
    logic          wp, rp;
    logic [1:0]    cnt;

    assign arst_n    = ~srst;
    assign buf_full  = (cnt == 2'd2);
    assign buf_empty = (cnt == 2'd0);

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wp        <= 1'b0;
            rp        <= 1'b0;
            cnt       <= 2'd0;
            buf_rdata <= '0;
        end else begin
            if (buf_wr_en) begin
                mem[wp] <= buf_wdata;
                wp      <= ~wp;
            end
            if (buf_rd_en) begin
                buf_rdata <= mem[rp];
                rp        <= ~rp;
            end
            cnt <= cnt + {1'b0, buf_wr_en} - {1'b0, buf_rd_en};
        end
    end

    // The buffer treats overflow/underflow as fatal; flag them as failures.
    always @(posedge clk) begin
        if (!srst && buf_wr_en) begin
            checks++;
            assert (buf_full === 1'b0) else begin
                errors++;
                $error("FAIL buf_overflow observed full=%0b expected 0", buf_full);
            end
        end
        if (!srst && buf_rd_en) begin
            checks++;
            assert (buf_empty === 1'b0) else begin
                errors++;
                $error("FAIL buf_underflow observed empty=%0b expected 0", buf_empty);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2);
        req_valid = v;
        req_data  = {d2, d1, d0};
    endtask

    // Inputs change on the falling edge; checks run 1 ns later, well before the rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        srst      = 1'b1;
        out_ready = 1'b1;
        drive(3'b000, 8'h00, 8'h00, 8'h00);

        // Reset: grants and buffer strobes forced low while srst is high.
        step(); srst = 1'b1; drive(3'b111, 8'h10, 8'h20, 8'h30); #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_en", 32'(buf_wr_en), 32'h0);
        chk("rst_rd_en", 32'(buf_rd_en), 32'h0);
        step(); srst = 1'b0; drive(3'b000, 8'h00, 8'h00, 8'h00); #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);

        // Fairness: all three valid, grants rotate 0,1,2,0,1,2; output trails by 2 cycles.
        for (int i = 0; i < 6; i++) begin
            step(); drive(3'b111, 8'h10, 8'h20, 8'h30); #1;
            chk("fair_ready", 32'(req_ready), 32'(1 << (i % 3)));
            chk("fair_wdata", 32'(buf_wdata), 32'({2'(i % 3), 8'((i % 3 + 1) * 16)}));
            if (i >= 2) begin
                chk("fair_out_valid", 32'(out_valid), 32'h1);
                chk("fair_out_src", 32'(out_src), 32'((i - 2) % 3));
                chk("fair_out_data", 32'(out_data), 32'(((i - 2) % 3 + 1) * 16));
            end else begin
                chk("fair_out_valid_early", 32'(out_valid), 32'h0);
            end
        end
        step(); drive(3'b000, 8'h00, 8'h00, 8'h00); #1;
        chk("fair_tail_src1", 32'(out_src), 32'h1);
        chk("fair_tail_data1", 32'(out_data), 32'h20);
        step(); #1;
        chk("fair_tail_src2", 32'(out_src), 32'h2);
        chk("fair_tail_data2", 32'(out_data), 32'h30);
        step(); #1;
        chk("fair_idle", 32'(idle), 32'h1);

        // Latency: req2 writes 0x5C at cycle 0, visible at cycle 2.
        step(); drive(3'b100, 8'h00, 8'h00, 8'h5C); #1;
        chk("lat_ready", 32'(req_ready), 32'h4);
        chk("lat_wr_en", 32'(buf_wr_en), 32'h1);
        step(); drive(3'b000, 8'h00, 8'h00, 8'h00); #1;
        chk("lat_c1_valid", 32'(out_valid), 32'h0);
        chk("lat_c1_rd_en", 32'(buf_rd_en), 32'h1);
        step(); #1;
        chk("lat_c2_valid", 32'(out_valid), 32'h1);
        chk("lat_c2_data", 32'(out_data), 32'h5C);
        chk("lat_c2_src", 32'(out_src), 32'h2);
        step(); #1;
        chk("lat_idle", 32'(idle), 32'h1);

        // Full stall: consumer stalled, req0 streams A1..A4 into a 2-entry buffer.
        out_ready = 1'b0;
        step(); drive(3'b001, 8'hA1, 8'h00, 8'h00); #1;
        chk("full_a1_ready", 32'(req_ready), 32'h1);
        step(); drive(3'b001, 8'hA2, 8'h00, 8'h00); #1;
        chk("full_a2_ready", 32'(req_ready), 32'h1);
        chk("full_a2_rd_en", 32'(buf_rd_en), 32'h1);
        step(); drive(3'b001, 8'hA3, 8'h00, 8'h00); #1;
        chk("full_a3_ready", 32'(req_ready), 32'h1);
        chk("full_a3_rd_en", 32'(buf_rd_en), 32'h0);
        chk("full_a3_out", 32'(out_data), 32'hA1);
        for (int i = 0; i < 3; i++) begin
            step(); drive(3'b001, 8'hA4, 8'h00, 8'h00); #1;
            chk("full_flag", 32'(buf_full), 32'h1);
            chk("full_ready", 32'(req_ready), 32'h0);
            chk("full_wr_en", 32'(buf_wr_en), 32'h0);
            chk("full_out_hold", 32'(out_data), 32'hA1);
        end
        step(); out_ready = 1'b1; #1;
        chk("drain_full_ready", 32'(req_ready), 32'h0);
        chk("drain_rd_en", 32'(buf_rd_en), 32'h1);
        chk("drain_a1", 32'(out_data), 32'hA1);
        step(); #1;
        chk("drain_a4_ready", 32'(req_ready), 32'h1);
        chk("drain_a2", 32'(out_data), 32'hA2);
        step(); drive(3'b000, 8'h00, 8'h00, 8'h00); #1;
        chk("drain_a3", 32'(out_data), 32'hA3);
        step(); #1;
        chk("drain_a4", 32'(out_data), 32'hA4);
        chk("drain_a4_valid", 32'(out_valid), 32'h1);
        step(); #1;
        chk("drain_idle", 32'(idle), 32'h1);

        // Backpressure: 0x11 held for 5 stalled cycles with 0x22 waiting in the buffer.
        out_ready = 1'b0;
        step(); drive(3'b010, 8'h00, 8'h11, 8'h00); #1;
        chk("bp_ready1", 32'(req_ready), 32'h2);
        step(); drive(3'b100, 8'h00, 8'h00, 8'h22); #1;
        chk("bp_ready2", 32'(req_ready), 32'h4);
        step(); drive(3'b000, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) step();
            #1;
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data", 32'(out_data), 32'h11);
            chk("bp_src", 32'(out_src), 32'h1);
            chk("bp_rd_en", 32'(buf_rd_en), 32'h0);
        end
        step(); out_ready = 1'b1; #1;
        chk("bp_release_rd_en", 32'(buf_rd_en), 32'h1);
        step(); #1;
        chk("bp_next_data", 32'(out_data), 32'h22);
        chk("bp_next_src", 32'(out_src), 32'h2);
        step(); #1;
        chk("bp_idle", 32'(idle), 32'h1);

        // Reset mid-stream: req1 fills the buffer (pointer left at 2), then srst for 1 cycle.
        out_ready = 1'b0;
        step(); drive(3'b010, 8'h00, 8'h01, 8'h00); #1;
        chk("mr_ready0", 32'(req_ready), 32'h2);
        step(); drive(3'b010, 8'h00, 8'h02, 8'h00); #1;
        chk("mr_ready1", 32'(req_ready), 32'h2);
        step(); drive(3'b010, 8'h00, 8'h03, 8'h00); #1;
        chk("mr_ready2", 32'(req_ready), 32'h2);
        step(); drive(3'b111, 8'h00, 8'h00, 8'h00); #1;
        chk("mr_ov_before", 32'(out_valid), 32'h1);
        srst = 1'b1; #1;
        chk("mr_srst_ready", 32'(req_ready), 32'h0);
        chk("mr_srst_wr_en", 32'(buf_wr_en), 32'h0);
        chk("mr_srst_rd_en", 32'(buf_rd_en), 32'h0);
        step(); srst = 1'b0; drive(3'b110, 8'h00, 8'h77, 8'h88); #1;
        chk("mr_out_valid", 32'(out_valid), 32'h0);
        chk("mr_idle", 32'(idle), 32'h1);
        chk("mr_ptr_grant", 32'(req_ready), 32'h2);
        chk("mr_wdata", 32'(buf_wdata), 32'({2'd1, 8'h77}));
        step(); drive(3'b000, 8'h00, 8'h00, 8'h00); out_ready = 1'b1; #1;
        chk("mr_rd_en", 32'(buf_rd_en), 32'h1);
        step(); #1;
        chk("mr_out_data", 32'(out_data), 32'h77);
        chk("mr_out_src", 32'(out_src), 32'h1);
        step(); #1;
        chk("mr_final_idle", 32'(idle), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
